// File: rtl/fake_n64_pkg.sv
// Shared definitions for the fake N64 controller: wire-level timing, command codes
// and receiver state encodings used by both the rx and tx halves.
package fake_n64_pkg;

    localparam int LEVEL_WIDTH = 2;
    localparam int BIT_WIDTH   = 4 * LEVEL_WIDTH;
    localparam int CNT_W       = 6;

    // Low time of each symbol, in LEVEL_WIDTH units; the rest of BIT_WIDTH is high.
    localparam int ONE_LOW_LEVELS  = 1;
    localparam int ZERO_LOW_LEVELS = 3;
    localparam int STOP_LOW_LEVELS = 1;
    localparam logic LINE_IDLE     = 1'b1;

    localparam logic [7:0] CMD_INFO   = 8'h00;
    localparam logic [7:0] CMD_STATUS = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_WRITE  = 8'h03;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    typedef enum logic [2:0] {
        RX_RECOVER = 3'd0,
        RX_IDLE    = 3'd1,
        RX_LOW     = 3'd2,
        RX_HIGH    = 3'd3,
        RX_STOP    = 3'd4,
        RX_HANDOFF = 3'd5
    } rx_state_t;

    function automatic logic [CNT_W-1:0] cnt_const(input int v);
        return CNT_W'(v);
    endfunction

endpackage

// File: rtl/fake_n64_line_sync.sv
// Synchronizes the raw Joybus line into the sample clock domain and produces
// single-cycle fall/rise strobes from the registered line level.
module fake_n64_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_line,
    output logic o_line_s,
    output logic o_fall,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_line_s;
    logic                   r_line_prev;

    // Flops reset high so a reset never looks like the start of a frame.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync      <= '1;
            r_line_s    <= 1'b1;
            r_line_prev <= 1'b1;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], i_line};
            r_line_s    <= r_sync[SYNC_STAGES-1];
            r_line_prev <= r_line_s;
        end
    end

    assign o_line_s = r_line_s;
    assign o_fall   = r_line_prev & ~r_line_s;
    assign o_rise   = ~r_line_prev & r_line_s;

endmodule

// File: rtl/fake_n64_controller_rx.sv
// Console-to-controller receiver: measures low pulses, decodes a command byte
// MSB first, checks the stop bit, then hands the line to the tx half.
module fake_n64_controller_rx #(
    parameter int LEVEL_WIDTH = 2,
    parameter int CMD_BITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   i_sample_clk,
    input  logic                   i_reset,
    input  logic                   i_data_rx,
    input  logic                   i_rx_handoff,
    output logic [CMD_BITS-1:0]    o_cmd,
    output logic                   o_cmd_valid,
    output logic                   o_cur_operation,
    output logic                   o_rx_error,
    output fake_n64_pkg::rx_state_t o_dbg_state
);

    import fake_n64_pkg::*;

    localparam int IDX_W = $clog2(CMD_BITS + 1);
    localparam logic [CNT_W-1:0] ONE_MAX_CNT = cnt_const(2 * LEVEL_WIDTH);
    localparam logic [CNT_W-1:0] LIMIT_CNT   = cnt_const(4 * LEVEL_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(CMD_BITS);

    logic w_line_s;
    logic w_fall;
    logic w_rise;

    rx_state_t           r_state;
    logic [CNT_W-1:0]    r_low_cnt;
    logic [CNT_W-1:0]    r_high_cnt;
    logic [IDX_W-1:0]    r_bit_idx;
    logic [CMD_BITS-1:0] r_sreg;
    logic [CMD_BITS-1:0] r_cmd;
    logic                r_cmd_valid;
    logic                r_cur_op;
    logic                r_rx_error;

    fake_n64_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .i_clk   (i_sample_clk),
        .i_reset (i_reset),
        .i_line  (i_data_rx),
        .o_line_s(w_line_s),
        .o_fall  (w_fall),
        .o_rise  (w_rise)
    );

    // Saturating level-time counters; each clears while the opposite level is seen.
    always_ff @(posedge i_sample_clk) begin
        if (i_reset) begin
            r_low_cnt  <= '0;
            r_high_cnt <= '0;
        end else if (w_line_s) begin
            r_low_cnt <= '0;
            if (r_high_cnt != '1) r_high_cnt <= r_high_cnt + 1'b1;
        end else begin
            r_high_cnt <= '0;
            if (r_low_cnt != '1) r_low_cnt <= r_low_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_sample_clk) begin
        if (i_reset) begin
            r_state     <= RX_RECOVER;
            r_bit_idx   <= '0;
            r_sreg      <= '0;
            r_cmd       <= '0;
            r_cmd_valid <= 1'b0;
            r_cur_op    <= 1'b0;
            r_rx_error  <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_rx_error  <= 1'b0;
            case (r_state)
                RX_RECOVER: begin
                    if (r_high_cnt >= LIMIT_CNT) r_state <= RX_IDLE;
                end
                RX_IDLE: begin
                    if (w_fall) begin
                        r_bit_idx <= '0;
                        r_state   <= RX_LOW;
                    end
                end
                RX_LOW: begin
                    if (r_low_cnt >= LIMIT_CNT) begin
                        r_rx_error <= 1'b1;
                        r_state    <= RX_RECOVER;
                    end else if (w_rise && (r_bit_idx < LAST_IDX)) begin
                        // A short low pulse is a '1', a long one a '0'.
                        r_sreg    <= {r_sreg[CMD_BITS-2:0], (r_low_cnt < ONE_MAX_CNT)};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        r_state   <= RX_HIGH;
                    end
                end
                RX_HIGH: begin
                    if (r_high_cnt >= LIMIT_CNT) begin
                        r_rx_error <= 1'b1;
                        r_state    <= RX_RECOVER;
                    end else if (w_fall) begin
                        r_state <= (r_bit_idx < LAST_IDX) ? RX_LOW : RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (w_rise) begin
                        if (r_low_cnt < ONE_MAX_CNT) begin
                            r_cmd       <= r_sreg;
                            r_cmd_valid <= 1'b1;
                            r_cur_op    <= 1'b1;
                            r_state     <= RX_HANDOFF;
                        end else begin
                            r_rx_error <= 1'b1;
                            r_state    <= RX_RECOVER;
                        end
                    end else if (r_low_cnt >= LIMIT_CNT) begin
                        r_rx_error <= 1'b1;
                        r_state    <= RX_RECOVER;
                    end
                end
                RX_HANDOFF: begin
                    if (i_rx_handoff) begin
                        r_cur_op <= 1'b0;
                        r_state  <= RX_RECOVER;
                    end
                end
                default: r_state <= RX_RECOVER;
            endcase
        end
    end

    assign o_cmd           = r_cmd;
    assign o_cmd_valid     = r_cmd_valid;
    assign o_cur_operation = r_cur_op;
    assign o_rx_error      = r_rx_error;
    assign o_dbg_state     = r_state;

endmodule
